// File: rtl/cnt_load_sched.sv
// Round-robin load arbiter and run/hold sequencer for an external 8-bit loadable up-counter.
// All outputs are registered; the counter is frozen by rewriting its own next value each cycle.
module cnt_load_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_stop,
  input  logic [WIDTH-1:0]      tc_value,
  input  logic [WIDTH-1:0]      cnt_data,
  output logic                  cnt_wr,
  output logic [WIDTH-1:0]      cnt_wdata,
  output logic                  running,
  output logic                  tc_hit
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ACT_GRANT,
    ACT_RUN,
    ACT_HOLD
  } action_t;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    win;
  logic             found;
  logic [NREQ-1:0]  gnt_onehot;
  logic [WIDTH-1:0] data_arr [NREQ];
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] nv;
  logic             tc_cond;
  logic             run_nxt;
  action_t          action;

  for (genvar i = 0; i < NREQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  // First requester at or above ptr, wrapping around, wins.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = PW'((int'(ptr) + j) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    if (int'(win) == NREQ - 1) ptr_nxt = '0;
    else                       ptr_nxt = win + 1'b1;
  end

  assign gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign win_data   = data_arr[win];

  // Value the counter takes at this edge, given what we are driving into it right now.
  assign inc     = cnt_data + 1'b1;
  assign nv      = cnt_wr ? cnt_wdata : inc;
  assign tc_cond = !cnt_wr && (inc == tc_value);

  always_comb begin
    if (stop)                       run_nxt = 1'b0;
    else if (auto_stop && tc_cond)  run_nxt = 1'b0;
    else if (start)                 run_nxt = 1'b1;
    else                            run_nxt = running;
  end

  always_comb begin
    if (found)        action = ACT_GRANT;
    else if (run_nxt) action = ACT_RUN;
    else              action = ACT_HOLD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      cnt_wr    <= 1'b0;
      cnt_wdata <= '0;
      running   <= 1'b0;
      tc_hit    <= 1'b0;
      ptr       <= '0;
    end else begin
      running <= run_nxt;
      tc_hit  <= tc_cond;
      unique case (action)
        ACT_GRANT: begin
          gnt       <= gnt_onehot;
          cnt_wr    <= 1'b1;
          cnt_wdata <= win_data;
          ptr       <= ptr_nxt;
        end
        ACT_RUN: begin
          gnt    <= '0;
          cnt_wr <= 1'b0;
        end
        default: begin
          // Hold: rewrite the value the counter is about to take, freezing it there.
          gnt       <= '0;
          cnt_wr    <= 1'b1;
          cnt_wdata <= nv;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_load_sched.sv
// Bench for cnt_load_sched: drives an attached counter and compares against a cycle model
// built from the arbitration, run/stop and terminal-count rules.
module tb_cnt_load_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int MODV  = 1 << WIDTH;
  localparam int VW    = NREQ + 3 + WIDTH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  start;
  logic                  stop;
  logic                  auto_stop;
  logic [WIDTH-1:0]      tc_value;
  logic [WIDTH-1:0]      cnt_data;
  logic                  cnt_wr;
  logic [WIDTH-1:0]      cnt_wdata;
  logic                  running;
  logic                  tc_hit;
  logic [VW-1:0]         dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: counter value, registered outputs and round-robin pointer.
  int m_cnt, m_wdata, m_ptr, m_gnt;
  bit m_wr, m_run, m_tc;

  always #5 clk = ~clk;

  // The loadable up-counter being controlled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_data <= '0;
    else if (cnt_wr) cnt_data <= cnt_wdata;
    else             cnt_data <= cnt_data + 1'b1;
  end

  cnt_load_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .start     (start),
    .stop      (stop),
    .auto_stop (auto_stop),
    .tc_value  (tc_value),
    .cnt_data  (cnt_data),
    .cnt_wr    (cnt_wr),
    .cnt_wdata (cnt_wdata),
    .running   (running),
    .tc_hit    (tc_hit)
  );

  assign dut_vec = {gnt, cnt_wr, running, tc_hit, cnt_data};

  function automatic logic [VW-1:0] exp_vec();
    return {NREQ'(m_gnt), m_wr, m_run, m_tc, WIDTH'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wdata = 0; m_ptr = 0; m_gnt = 0;
    m_wr = 0; m_run = 0; m_tc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; req_data = '0; start = 1'b0; stop = 1'b0;
    auto_stop = 1'b0; tc_value = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Advance one clock: predict from the rules, step, then release pulses and granted requests.
  task automatic tick();
    int inc, nv, k;
    bit tc, rn;
    inc = (m_cnt + 1) % MODV;
    nv  = m_wr ? m_wdata : inc;
    tc  = !m_wr && (inc == int'(tc_value));
    if (stop)                   rn = 0;
    else if (auto_stop && tc)   rn = 0;
    else if (start)             rn = 1;
    else                        rn = m_run;
    k = -1;
    for (int j = 0; j < NREQ; j++) begin
      int c;
      c = (m_ptr + j) % NREQ;
      if (k < 0 && req[c]) k = c;
    end
    m_cnt = nv;
    m_tc  = tc;
    m_run = rn;
    if (k >= 0) begin
      m_gnt = 1 << k; m_wr = 1;
      m_wdata = int'(req_data[k*WIDTH +: WIDTH]);
      m_ptr = (k + 1) % NREQ;
    end else if (rn) begin
      m_gnt = 0; m_wr = 0;
    end else begin
      m_gnt = 0; m_wr = 1; m_wdata = nv;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (k >= 0) req[k] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({gnt, cnt_wr, cnt_wdata, running, tc_hit, cnt_data} !== '0)
      $display("FAIL reset_state: got %h, expected 0",
               {gnt, cnt_wr, cnt_wdata, running, tc_hit, cnt_data});
    else n_pass++;
  endtask

  task automatic test_count();
    do_reset();
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || cnt_data !== WIDTH'(i) || running !== 1'b1 || cnt_wr !== 1'b0)
        $display("FAIL count_%0d: got %h, expected %h (cnt %h)", i, dut_vec, exp_vec(), WIDTH'(i));
      else n_pass++;
    end
  endtask

  task automatic test_stop_hold();
    int budget;
    logic [WIDTH-1:0] resume [3];
    resume = '{8'h11, 8'h12, 8'h13};
    do_reset();
    req_data[0 +: WIDTH] = 8'h0E;
    req   = 4'b0001;
    start = 1'b1;
    budget = 0;
    while (!(m_cnt == 8'h10 && m_run && !m_wr) && budget < 10) begin
      tick();
      budget++;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL stop_setup: got %h, expected %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (budget >= 10) $display("FAIL stop_setup_budget: counter never reached 10, at %h", cnt_data);
    else n_pass++;
    stop = 1'b1;
    tick();
    n_checks++;
    if (cnt_wr !== 1'b1 || cnt_wdata !== 8'h11 || running !== 1'b0)
      $display("FAIL stop_pulse: got wr=%b wdata=%h run=%b, expected wr=1 wdata=11 run=0",
               cnt_wr, cnt_wdata, running);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || cnt_data !== 8'h11 || cnt_wr !== 1'b1 || cnt_wdata !== 8'h11)
        $display("FAIL hold_%0d: got cnt=%h wr=%b wdata=%h, expected cnt=11 wr=1 wdata=11",
                 i, cnt_data, cnt_wr, cnt_wdata);
      else n_pass++;
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || cnt_data !== resume[i] || running !== 1'b1)
        $display("FAIL resume_%0d: got %h, expected %h (cnt %h)", i, dut_vec, exp_vec(), resume[i]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] d [NREQ];
    logic [NREQ-1:0] seq2 [3];
    logic [WIDTH-1:0] cnt2 [3];
    d = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = d[i];
    req = '1;
    for (int i = 0; i < NREQ; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || gnt !== NREQ'(1 << i) || (i > 0 && cnt_data !== d[i-1]))
        $display("FAIL rr_grant_%0d: got gnt=%b cnt=%h, expected gnt=%b", i, gnt, cnt_data,
                 NREQ'(1 << i));
      else n_pass++;
    end
    req  = 4'b1010;
    seq2 = '{4'b0010, 4'b1000, 4'b0000};
    cnt2 = '{8'hD3, 8'hB1, 8'hD3};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || gnt !== seq2[i] || cnt_data !== cnt2[i])
        $display("FAIL rr_regrant_%0d: got gnt=%b cnt=%h, expected gnt=%b cnt=%h",
                 i, gnt, cnt_data, seq2[i], cnt2[i]);
      else n_pass++;
    end
  endtask

  task automatic test_auto_stop();
    int hits;
    do_reset();
    tc_value  = 8'h05;
    auto_stop = 1'b1;
    start     = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || (tc_hit === 1'b1 && cnt_data !== 8'h05))
        $display("FAIL autostop_cycle_%0d: got %h, expected %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (tc_hit === 1'b1) hits++;
    end
    n_checks++;
    if (hits != 1 || running !== 1'b0 || cnt_data !== 8'h05)
      $display("FAIL autostop_end: got hits=%0d run=%b cnt=%h, expected hits=1 run=0 cnt=05",
               hits, running, cnt_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int hits;
    bit prev_tc;
    do_reset();
    tc_value = 8'h00;
    req_data[0 +: WIDTH] = 8'hFC;
    req   = 4'b0001;
    start = 1'b1;
    hits = 0;
    prev_tc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || (tc_hit === 1'b1 && cnt_data !== 8'h00) ||
          (prev_tc && cnt_data !== 8'h01))
        $display("FAIL wrap_cycle_%0d: got %h, expected %h", i, dut_vec, exp_vec());
      else n_pass++;
      prev_tc = (tc_hit === 1'b1);
      if (prev_tc) hits++;
    end
    n_checks++;
    if (hits != 1 || running !== 1'b1)
      $display("FAIL wrap_end: got hits=%0d run=%b, expected hits=1 run=1", hits, running);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int budget;
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || running !== 1'b0 || cnt_wr !== 1'b1)
      $display("FAIL start_stop_same: got run=%b wr=%b, expected run=0 wr=1", running, cnt_wr);
    else n_pass++;

    do_reset();
    tc_value  = 8'h05;
    auto_stop = 1'b1;
    start     = 1'b1;
    budget = 0;
    while (!(m_cnt == 4 && !m_wr) && budget < 10) begin
      tick();
      budget++;
    end
    n_checks++;
    if (budget >= 10 || cnt_data !== 8'h04 || running !== 1'b1)
      $display("FAIL tc_grant_setup: got cnt=%h run=%b, expected cnt=04 run=1", cnt_data, running);
    else n_pass++;
    req_data[2*WIDTH +: WIDTH] = 8'h40;
    req = 4'b0100;
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || gnt !== 4'b0100 || tc_hit !== 1'b1 || running !== 1'b0 ||
        cnt_wr !== 1'b1 || cnt_wdata !== 8'h40)
      $display("FAIL tc_grant_edge: got gnt=%b tc=%b run=%b wr=%b wdata=%h, expected 0100 1 0 1 40",
               gnt, tc_hit, running, cnt_wr, cnt_wdata);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || cnt_data !== 8'h40 || tc_hit !== 1'b0 || running !== 1'b0)
        $display("FAIL tc_grant_hold_%0d: got cnt=%h tc=%b run=%b, expected cnt=40 tc=0 run=0",
                 i, cnt_data, tc_hit, running);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b0010;
    start = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || running !== 1'b1)
      $display("FAIL mid_reset_setup: got gnt=%b run=%b, expected 0010 1", gnt, running);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (gnt !== '0 || cnt_wr !== 1'b0 || running !== 1'b0 || tc_hit !== 1'b0 || cnt_data !== '0)
      $display("FAIL mid_reset_async: got gnt=%b wr=%b run=%b tc=%b cnt=%h, expected all 0",
               gnt, cnt_wr, running, tc_hit, cnt_data);
    else n_pass++;
    req = 4'b0110;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || gnt !== 4'b0010)
      $display("FAIL mid_reset_rearb: got gnt=%b, expected 0010", gnt);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) auto_stop = ~auto_stop;
      if ($urandom_range(0, 9) == 0) tc_value = WIDTH'(m_cnt + $urandom_range(1, 6));
      for (int b = 0; b < NREQ; b++) begin
        if (!req[b] && $urandom_range(0, 5) == 0) begin
          req[b] = 1'b1;
          req_data[b*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if (req[b] && $urandom_range(0, 19) == 0) begin
          req[b] = 1'b0;
        end
      end
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || (m_wr && cnt_wdata !== WIDTH'(m_wdata)))
        $display("FAIL random_%0d: got %h/%h, expected %h/%h", cyc, dut_vec, cnt_wdata,
                 exp_vec(), WIDTH'(m_wdata));
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0; req_data = '0; start = 1'b0; stop = 1'b0;
    auto_stop = 1'b0; tc_value = '0;
    model_reset();
    test_reset();
    test_count();
    test_stop_hold();
    test_round_robin();
    test_auto_stop();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
